// File: rtl/bulls_cows_engine.sv
// Bulls-and-Cows game engine: secret/guess capture, serial A/B scoring, try
// accounting and a three-row text overlay addressed through an external font ROM.
module bulls_cows_engine #(
    parameter int DIGITS    = 3,
    parameter int MAX_TRIES = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                new_game,
    input  logic [4*DIGITS-1:0] num_in,
    input  logic                num_rdy,
    output logic                busy,
    output logic                num_err,
    output logic [2:0]          state,
    output logic [3:0]          a_cnt,
    output logic [3:0]          b_cnt,
    output logic [3:0]          tries,
    output logic                score_vld,
    input  logic [9:0]          pix_x,
    input  logic [9:0]          pix_y,
    output logic [10:0]         rom_addr,
    input  logic [7:0]          font_word,
    output logic                text_on,
    output logic [2:0]          text_rgb
);
    localparam int CW = 4 * DIGITS;

    typedef enum logic [2:0] {
        ST_WAIT_SECRET = 3'd0,
        ST_PLAY        = 3'd1,
        ST_SCORE       = 3'd2,
        ST_WIN         = 3'd3,
        ST_LOSE        = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] secret_q, secret_d;
    logic [CW-1:0] guess_q, guess_d;
    logic [3:0]    idx_q, idx_d;
    logic [3:0]    a_acc_q, a_acc_d;
    logic [3:0]    hist_g_q [16];
    logic [3:0]    hist_g_d [16];
    logic [3:0]    hist_s_q [16];
    logic [3:0]    hist_s_d [16];
    logic [3:0]    a_cnt_q, a_cnt_d;
    logic [3:0]    b_cnt_q, b_cnt_d;
    logic [3:0]    tries_q, tries_d;
    logic          score_vld_q, score_vld_d;
    logic          num_err_q, num_err_d;
    logic          scored_q, scored_d;
    logic          text_on_q;
    logic [2:0]    bit_q;

    function automatic logic digits_ok(input logic [CW-1:0] code);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++)
            if (code[4*i +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [3:0] digit_at(input logic [CW-1:0] code, input logic [3:0] idx);
        logic [3:0] d;
        d = '0;
        for (int i = 0; i < DIGITS; i++)
            if (idx == 4'(i)) d = code[4*i +: 4];
        return d;
    endfunction

    // ---------------- scoring datapath ----------------
    logic [3:0] g_dig, s_dig;
    logic [4:0] matched;
    logic [3:0] tries_inc;

    always_comb begin
        g_dig     = digit_at(guess_q, idx_q);
        s_dig     = digit_at(secret_q, idx_q);
        // Total common digits, duplicates included, is the sum of per-value minima.
        matched   = '0;
        for (int v = 0; v < 10; v++)
            matched += (hist_g_q[v] < hist_s_q[v]) ? {1'b0, hist_g_q[v]} : {1'b0, hist_s_q[v]};
        tries_inc = (tries_q == 4'hF) ? tries_q : tries_q + 4'd1;
    end

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no path leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        secret_d    = secret_q;
        guess_d     = guess_q;
        idx_d       = idx_q;
        a_acc_d     = a_acc_q;
        hist_g_d    = hist_g_q;
        hist_s_d    = hist_s_q;
        a_cnt_d     = a_cnt_q;
        b_cnt_d     = b_cnt_q;
        tries_d     = tries_q;
        scored_d    = scored_q;
        score_vld_d = 1'b0;
        num_err_d   = 1'b0;

        if (new_game) begin
            state_d  = ST_WAIT_SECRET;
            guess_d  = '0;
            a_cnt_d  = '0;
            b_cnt_d  = '0;
            tries_d  = '0;
            scored_d = 1'b0;
        end else begin
            case (state_q)
                ST_WAIT_SECRET: begin
                    if (num_rdy) begin
                        if (digits_ok(num_in)) begin
                            secret_d = num_in;
                            state_d  = ST_PLAY;
                        end else begin
                            num_err_d = 1'b1;
                        end
                    end
                end
                ST_PLAY: begin
                    if (num_rdy) begin
                        if (digits_ok(num_in)) begin
                            guess_d = num_in;
                            idx_d   = '0;
                            a_acc_d = '0;
                            for (int v = 0; v < 16; v++) begin
                                hist_g_d[v] = '0;
                                hist_s_d[v] = '0;
                            end
                            state_d = ST_SCORE;
                        end else begin
                            num_err_d = 1'b1;
                        end
                    end
                end
                ST_SCORE: begin
                    if (idx_q < 4'(DIGITS)) begin
                        if (g_dig == s_dig) a_acc_d = a_acc_q + 4'd1;
                        hist_g_d[g_dig] = hist_g_q[g_dig] + 4'd1;
                        hist_s_d[s_dig] = hist_s_q[s_dig] + 4'd1;
                        idx_d = idx_q + 4'd1;
                    end else begin
                        a_cnt_d     = a_acc_q;
                        b_cnt_d     = 4'(matched - {1'b0, a_acc_q});
                        tries_d     = tries_inc;
                        score_vld_d = 1'b1;
                        scored_d    = 1'b1;
                        if (a_acc_q == 4'(DIGITS))
                            state_d = ST_WIN;
                        else if (tries_inc == 4'(MAX_TRIES))
                            state_d = ST_LOSE;
                        else
                            state_d = ST_PLAY;
                    end
                end
                ST_WIN, ST_LOSE: state_d = state_q;
                default:         state_d = ST_WAIT_SECRET;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_WAIT_SECRET;
            secret_q    <= '0;
            guess_q     <= '0;
            idx_q       <= '0;
            a_acc_q     <= '0;
            a_cnt_q     <= '0;
            b_cnt_q     <= '0;
            tries_q     <= '0;
            score_vld_q <= 1'b0;
            num_err_q   <= 1'b0;
            scored_q    <= 1'b0;
            // NOTE: the histograms are cleared on every entry to SCORE; resetting them only keeps them X-free.
            for (int v = 0; v < 16; v++) begin
                hist_g_q[v] <= '0;
                hist_s_q[v] <= '0;
            end
        end else begin
            state_q     <= state_d;
            secret_q    <= secret_d;
            guess_q     <= guess_d;
            idx_q       <= idx_d;
            a_acc_q     <= a_acc_d;
            a_cnt_q     <= a_cnt_d;
            b_cnt_q     <= b_cnt_d;
            tries_q     <= tries_d;
            score_vld_q <= score_vld_d;
            num_err_q   <= num_err_d;
            scored_q    <= scored_d;
            hist_g_q    <= hist_g_d;
            hist_s_q    <= hist_s_d;
        end
    end

    assign busy      = (state_q == ST_SCORE);
    assign num_err   = num_err_q;
    assign state     = state_q;
    assign a_cnt     = a_cnt_q;
    assign b_cnt     = b_cnt_q;
    assign tries     = tries_q;
    assign score_vld = score_vld_q;

    // ---------------- text overlay ----------------
    function automatic logic [95:0] code_str(input logic [CW-1:0] code);
        logic [95:0] s;
        s = '0;
        for (int j = 0; j < DIGITS; j++)
            s[8*(11-j) +: 8] = 8'h30 + {4'h0, code[4*(DIGITS-1-j) +: 4]};
        return s;
    endfunction

    function automatic logic [7:0] pick(input logic [95:0] s, input logic [3:0] k);
        logic [7:0] c;
        c = '0;
        for (int i = 0; i < 12; i++)
            if (k == 4'(i)) c = s[8*(11-i) +: 8];
        return c;
    endfunction

    logic [3:0]  txt_row;
    logic [4:0]  col;
    logic [3:0]  slot;
    logic        in_region;
    logic [4:0]  turn;
    logic [7:0]  tens_ch, ones_ch;
    logic [95:0] row_str;
    logic [7:0]  ch;

    always_comb begin
        txt_row   = pix_y[9:6];
        col       = pix_x[9:5];
        slot      = 4'(col - 5'd4);
        in_region = (txt_row >= 4'd1) && (txt_row <= 4'd3) && (col >= 5'd4) && (col <= 5'd15);
        turn      = {1'b0, tries_q} + 5'd1;
        tens_ch   = (turn >= 5'd10) ? 8'h31 : 8'h30;
        ones_ch   = 8'h30 + {4'h0, (turn >= 5'd10) ? 4'(turn - 5'd10) : turn[3:0]};
        row_str   = '0;
        case (txt_row)
            4'd1: begin
                case (state_q)
                    ST_WAIT_SECRET:   row_str = {"SET CODE", 32'h0};
                    ST_PLAY, ST_SCORE: row_str = {"GUESS ", tens_ch, ones_ch, 32'h0};
                    ST_WIN:           row_str = {"YOU WIN", 40'h0};
                    ST_LOSE:          row_str = {"GAME OVER", 24'h0};
                    default:          row_str = '0;
                endcase
            end
            4'd2: if (state_q != ST_WAIT_SECRET) row_str = code_str(guess_q);
            4'd3: begin
                if (state_q == ST_LOSE)
                    row_str = code_str(secret_q);
                else if (scored_q)
                    row_str = {8'h30 + {4'h0, a_cnt_q}, "A ", 8'h30 + {4'h0, b_cnt_q}, "B", 56'h0};
            end
            default: row_str = '0;
        endcase
        ch = in_region ? pick(row_str, slot) : 8'h00;
    end

    assign rom_addr = {ch[6:0], pix_y[5:2]};

    logic unused_bits;
    assign unused_bits = ^{ch[7], pix_x[1:0], pix_y[1:0]};

    // Region and glyph column are delayed one cycle to line up with the ROM read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            text_on_q <= 1'b0;
            bit_q     <= '0;
        end else begin
            text_on_q <= in_region;
            bit_q     <= pix_x[4:2];
        end
    end

    assign text_on  = text_on_q;
    assign text_rgb = (text_on_q && font_word[~bit_q]) ? 3'b000 : 3'b111;

endmodule

// File: tb/tb_bulls_cows_engine.sv
// Scoreboard bench for bulls_cows_engine: directed stimulus pushes expected
// scores/errors into queues, a negedge monitor pops and compares them.
module tb_bulls_cows_engine;
    localparam int DIGITS    = 3;
    localparam int MAX_TRIES = 2;
    localparam int CW        = 4 * DIGITS;
    localparam int K_NONE    = 0;
    localparam int K_ERR     = 1;
    localparam int K_SCORE   = 2;
    localparam logic [2:0] S_WAIT  = 3'd0;
    localparam logic [2:0] S_PLAY  = 3'd1;
    localparam logic [2:0] S_SCORE = 3'd2;
    localparam logic [2:0] S_WIN   = 3'd3;
    localparam logic [2:0] S_LOSE  = 3'd4;

    logic          clk = 1'b0;
    logic          reset;
    logic          new_game;
    logic [CW-1:0] num_in;
    logic          num_rdy;
    logic          busy, num_err, score_vld, text_on;
    logic [2:0]    state, text_rgb;
    logic [3:0]    a_cnt, b_cnt, tries;
    logic [9:0]    pix_x, pix_y;
    logic [10:0]   rom_addr;
    logic [7:0]    font_word;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] t;
        logic [2:0] st;
        int         rdy_cyc;
    } exp_t;

    exp_t score_q[$];
    int   err_q[$];
    exp_t mon_e;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    bulls_cows_engine #(.DIGITS(DIGITS), .MAX_TRIES(MAX_TRIES)) dut (
        .clk(clk), .reset(reset), .new_game(new_game), .num_in(num_in), .num_rdy(num_rdy),
        .busy(busy), .num_err(num_err), .state(state), .a_cnt(a_cnt), .b_cnt(b_cnt),
        .tries(tries), .score_vld(score_vld), .pix_x(pix_x), .pix_y(pix_y),
        .rom_addr(rom_addr), .font_word(font_word), .text_on(text_on), .text_rgb(text_rgb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per score_vld / num_err pulse.
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            if (score_vld) begin
                if (score_q.size() == 0) begin
                    check("score_vld unexpected", score_vld, 1'b0);
                end else begin
                    mon_e = score_q.pop_front();
                    check("a_cnt", a_cnt, mon_e.a);
                    check("b_cnt", b_cnt, mon_e.b);
                    check("tries", tries, mon_e.t);
                    check("state after score", state, mon_e.st);
                    check("guess-to-score latency", cyc + 1 - mon_e.rdy_cyc, DIGITS + 2);
                end
            end
            if (num_err) begin
                if (err_q.size() == 0) check("num_err unexpected", num_err, 1'b0);
                else check("num_err cycle", cyc, err_q.pop_front());
            end
        end
    end

    task automatic drive(input logic [CW-1:0] num, input int kind,
                         input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] t, input logic [2:0] st);
        exp_t e;
        @(negedge clk);
        num_in  = num;
        num_rdy = 1'b1;
        if (kind == K_ERR) begin
            err_q.push_back(cyc + 1);
        end else if (kind == K_SCORE) begin
            e.a = a; e.b = b; e.t = t; e.st = st; e.rdy_cyc = cyc + 1;
            score_q.push_back(e);
        end
        @(negedge clk);
        num_rdy = 1'b0;
    endtask

    task automatic pulse_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((score_q.size() != 0 || err_q.size() != 0) && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("scoreboard drained in budget", score_q.size() + err_q.size(), 0);
    endtask

    task automatic glyph(input string name, input logic [9:0] x, input logic [9:0] y,
                         input logic [10:0] exp_addr);
        @(negedge clk);
        pix_x = x;
        pix_y = y;
        #1;
        check(name, rom_addr, exp_addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; new_game = 1'b0; num_rdy = 1'b0; num_in = '0;
        pix_x = '0; pix_y = '0; font_word = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset state", state, S_WAIT);
        check("reset busy", busy, 1'b0);
        check("reset num_err", num_err, 1'b0);
        check("reset score_vld", score_vld, 1'b0);
        check("reset a_cnt", a_cnt, 4'd0);
        check("reset b_cnt", b_cnt, 4'd0);
        check("reset tries", tries, 4'd0);
        check("reset text_on", text_on, 1'b0);
        check("reset text_rgb", text_rgb, 3'b111);

        // Exact match -> WIN after one guess.
        drive(12'h123, K_NONE, 0, 0, 0, 0);
        check("secret loaded -> PLAY", state, S_PLAY);
        drive(12'h123, K_SCORE, 4'd3, 4'd0, 4'd1, S_WIN);
        check("busy in SCORE", busy, 1'b1);
        check("state SCORE", state, S_SCORE);
        wait_drain();
        check("WIN holds", state, S_WIN);
        drive(12'hAAA, K_NONE, 0, 0, 0, 0);
        check("no num_err in WIN", num_err, 1'b0);
        @(negedge clk);
        check("WIN ignores num_rdy", state, S_WIN);

        // Overlay in WIN: 'Y' at column 4 of text row 1, text_on one cycle late.
        @(negedge clk);
        pix_x = 10'd128; pix_y = 10'd64; font_word = 8'h80;
        #1;
        check("rom_addr 'Y'", rom_addr, 11'h590);
        check("text_on before edge", text_on, 1'b0);
        @(posedge clk);
        #1;
        check("text_on after edge", text_on, 1'b1);
        check("text_rgb glyph bit", text_rgb, 3'b000);
        font_word = 8'h7F;
        #1;
        check("text_rgb blank bit", text_rgb, 3'b111);
        glyph("rom_addr 'O' row 5", 10'd160, 10'd84, 11'h4F5);
        glyph("rom_addr left of overlay", 10'd96, 10'd64, 11'h000);
        @(negedge clk);
        pix_x = '0; pix_y = '0; font_word = '0;

        // Duplicate digits, then a miss that exhausts MAX_TRIES.
        pulse_new_game();
        check("new_game -> WAIT", state, S_WAIT);
        check("new_game clears tries", tries, 4'd0);
        check("new_game clears a_cnt", a_cnt, 4'd0);
        drive(12'h112, K_NONE, 0, 0, 0, 0);
        drive(12'h121, K_SCORE, 4'd1, 4'd2, 4'd1, S_PLAY);
        wait_drain();
        glyph("row3 b digit '2'", 10'd224, 10'd192, 11'h320);
        glyph("row1 GUESS 02 ones", 10'd352, 10'd64, 11'h320);
        glyph("row2 guess leftmost '1'", 10'd128, 10'd128, 11'h310);
        drive(12'h333, K_SCORE, 4'd0, 4'd0, 4'd2, S_LOSE);
        wait_drain();
        glyph("LOSE row3 secret '1'", 10'd128, 10'd192, 11'h310);
        glyph("LOSE row1 'G'", 10'd128, 10'd64, 11'h470);

        // Bad digits, num_rdy while busy, second LOSE, ignore in LOSE.
        pulse_new_game();
        drive(12'h4B6, K_ERR, 0, 0, 0, 0);
        check("bad secret stays WAIT", state, S_WAIT);
        drive(12'h456, K_NONE, 0, 0, 0, 0);
        drive(12'h654, K_SCORE, 4'd1, 4'd2, 4'd1, S_PLAY);
        drive(12'h456, K_NONE, 0, 0, 0, 0);
        drive(12'hFFF, K_NONE, 0, 0, 0, 0);
        wait_drain();
        check("tries after 654", tries, 4'd1);
        drive(12'h0A0, K_ERR, 0, 0, 0, 0);
        @(negedge clk);
        check("bad guess keeps tries", tries, 4'd1);
        check("bad guess keeps PLAY", state, S_PLAY);
        drive(12'h000, K_SCORE, 4'd0, 4'd0, 4'd2, S_LOSE);
        wait_drain();
        drive(12'h456, K_NONE, 0, 0, 0, 0);
        @(negedge clk);
        check("LOSE ignores num_rdy", state, S_LOSE);
        check("LOSE keeps tries", tries, 4'd2);

        // new_game together with num_rdy two cycles into SCORE.
        pulse_new_game();
        drive(12'h789, K_NONE, 0, 0, 0, 0);
        drive(12'h780, K_SCORE, 4'd2, 4'd0, 4'd1, S_PLAY);
        wait_drain();
        drive(12'h789, K_NONE, 0, 0, 0, 0);
        @(negedge clk);
        new_game = 1'b1; num_rdy = 1'b1; num_in = 12'h123;
        @(negedge clk);
        new_game = 1'b0; num_rdy = 1'b0;
        check("abort -> WAIT", state, S_WAIT);
        check("abort clears tries", tries, 4'd0);
        check("abort clears a_cnt", a_cnt, 4'd0);
        check("abort clears b_cnt", b_cnt, 4'd0);
        repeat (8) @(negedge clk);
        check("abort stays WAIT", state, S_WAIT);

        // Asynchronous reset mid-SCORE.
        drive(12'h123, K_NONE, 0, 0, 0, 0);
        drive(12'h321, K_SCORE, 4'd1, 4'd2, 4'd1, S_PLAY);
        wait_drain();
        drive(12'h111, K_NONE, 0, 0, 0, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async reset state", state, S_WAIT);
        check("async reset busy", busy, 1'b0);
        check("async reset tries", tries, 4'd0);
        check("async reset a_cnt", a_cnt, 4'd0);
        check("async reset b_cnt", b_cnt, 4'd0);
        check("async reset score_vld", score_vld, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("post reset state", state, S_WAIT);

        check("final score queue empty", score_q.size(), 0);
        check("final err queue empty", err_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bulls_cows_engine.md
# bulls_cows_engine

Parametrised Bulls-and-Cows game engine for the VGA game datapath. It holds a DIGITS-wide secret and scores each guess serially into A (right digit, right place) and B (right digit, wrong place) counts. It counts attempts against a try limit, tracks win and lose, and drives a three-row text overlay through an external 1-cycle font ROM. It sits between the keypad digit collector and the VGA RGB mux.

## Interface
- DIGITS, 3, digits per code; legal range 2..8
- MAX_TRIES, 10, guesses allowed before LOSE; legal range 1..15
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- new_game  in  1  one-cycle pulse; abandons the current game and returns to WAIT_SECRET
- num_in  in  4*DIGITS  packed BCD code; digit i at [4i+3:4i]; digit DIGITS-1 is shown leftmost
- num_rdy  in  1  one-cycle pulse; num_in is valid
- busy  out  1  high in SCORE; num_rdy is ignored while high
- num_err  out  1  one-cycle pulse when an accepted-state num_rdy carries any digit >9
- state  out  3  0 WAIT_SECRET, 1 PLAY, 2 SCORE, 3 WIN, 4 LOSE
- a_cnt, b_cnt  out  4 each  score of the last guess
- tries  out  4  guesses scored this game
- score_vld  out  1  one-cycle pulse when a_cnt, b_cnt and tries update
- pix_x, pix_y  in  10 each  current pixel from the VGA sync unit
- rom_addr  out  11  {char[6:0], row[3:0]} to the font ROM
- font_word  in  8  ROM data, valid 1 cycle after rom_addr
- text_on  out  1  pixel lies inside the overlay; aligned with font_word
- text_rgb  out  3  000 on a glyph bit, 111 otherwise

## Operation
- Reset values: state=WAIT_SECRET. busy, num_err, score_vld, text_on = 0. a_cnt, b_cnt, tries = 0. Secret and last guess = 0. text_rgb=111.
- WAIT_SECRET:
  - num_rdy with all digits ≤9 loads the secret and moves to PLAY.
  - A bad digit pulses num_err and stays in WAIT_SECRET.
- PLAY:
  - num_rdy with all digits ≤9 latches the guess and moves to SCORE.
  - A bad digit pulses num_err; the guess is not latched and tries is unchanged.
- SCORE:
  - A = number of positions i with g[i]==s[i].
  - B = Σ over values v of min(count_g(v), count_s(v)) − A. Duplicate digits are legal and scored by this rule.
  - Evaluation is serial, one digit position per cycle.
- Score exit:
  - tries increments (saturating at 15).
  - If A==DIGITS, go to WIN.
  - Else if the new tries==MAX_TRIES, go to LOSE.
  - Else go to PLAY.
- WIN and LOSE hold until new_game or reset. num_rdy is ignored there and does not pulse num_err.
- new_game in any state, including mid-SCORE:
  - Next state is WAIT_SECRET; a_cnt, b_cnt, tries clear; no score_vld is emitted.
  - new_game has priority over a simultaneous num_rdy.
- Overlay cells are 32×64 px (glyph ×4): row = pix_y[5:2], bit = pix_x[4:2], column = pix_x[9:5]. The overlay covers columns 4..15 of text rows pix_y[9:6]=1..3.
  - Row 1, status by state: "SET CODE" (WAIT_SECRET), "GUESS nn" (PLAY/SCORE, nn = tries+1 in decimal), "YOU WIN" (WIN), "GAME OVER" (LOSE).
  - Row 2: last guess digits, starting at column 4; blank in WAIT_SECRET.
  - Row 3: "xA yB", or blank before the first score_vld of a game. In LOSE, row 3 shows the secret instead.
  - Characters are ASCII codes; unused cells are code 0x00.

## Timing
- num_rdy is sampled at edge t in PLAY.
  - busy=1 and state=SCORE from t+1 through t+DIGITS+1.
  - At t+DIGITS+2: a_cnt, b_cnt, tries update, score_vld=1 for one cycle, and state takes its next value.
  - Guess-to-score latency is DIGITS+2 cycles.
- num_err is asserted the cycle after the offending num_rdy.
- Overlay pipeline:
  - rom_addr is combinational from pix_x/pix_y.
  - pix_x[4:2] and the region decode are registered once, so text_on and text_rgb align with font_word.
  - text_rgb = font_word[~bit_d] ? 000 : 111 when text_on, else 111.
- reset asserted mid-SCORE clears everything immediately and asynchronously; no score_vld follows.

## Test plan
- DIGITS=3. Secret 1,2,3. Guess 1,2,3 -> score_vld exactly 5 cycles after num_rdy, a=3, b=0, tries=1, state=WIN.
- Secret 1,1,2. Guess 1,2,1 -> a=1, b=2. Then guess 3,3,3 -> a=0, b=0, tries=2.
- MAX_TRIES=2. Secret 4,5,6. Guesses 6,5,4 then 0,0,0 -> second score gives a=0, b=0, tries=2, state=LOSE. A further num_rdy is ignored.
- Guess containing digit 0xA in PLAY -> num_err pulse, tries unchanged, state stays PLAY. num_rdy asserted while busy -> no effect.
- new_game pulsed 2 cycles into SCORE, together with num_rdy -> state=WAIT_SECRET, a/b/tries=0, no score_vld. Async reset mid-SCORE -> all outputs at reset values before the next edge.
- Overlay: state=WIN with pix_y=64..127 and pix_x at column 4 -> rom_addr[10:4]=0x59 ('Y'). text_on and text_rgb lag that pix_x by exactly one cycle.
